// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a two-stage pixel pipeline and built-in test patterns.
// Counters start each line/frame in the front porch; the active region sits at the end.
module vga_timing_gen #(
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480,
    parameter int          HFP       = 40,
    parameter int          HPULSE    = 48,
    parameter int          HBP       = 40,
    parameter int          VFP       = 12,
    parameter int          VPULSE    = 3,
    parameter int          VBP       = 40,
    parameter logic        HS_POL    = 1'b0,
    parameter logic        VS_POL    = 1'b0,
    parameter logic [23:0] SOLID_RGB = 24'hFF0000
) (
    input  logic                       pixel_clk,
    input  logic                       pixel_rst,
    input  logic [1:0]                 pattern_sel,
    output logic                       pix_req,
    output logic [$clog2(HDISP)-1:0]   pix_x,
    output logic [$clog2(VDISP)-1:0]   pix_y,
    input  logic [23:0]                pix_in,
    output logic                       video_hs,
    output logic                       video_vs,
    output logic                       video_de,
    output logic [23:0]                video_rgb,
    output logic                       frame_start
);

    localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
    localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);
    localparam int XW     = $clog2(HDISP);
    localparam int YW     = $clog2(VDISP);
    localparam int BARW   = HDISP / 8;
    localparam int BW     = $clog2(BARW);

    localparam logic [HW-1:0] H_LAST   = HW'(HTOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_B = HW'(HFP);
    localparam logic [HW-1:0] H_SYNC_E = HW'(HFP + HPULSE);
    localparam logic [HW-1:0] H_ACT    = HW'(HTOTAL - HDISP);
    localparam logic [HW-1:0] H_BIT4   = HW'(16);
    localparam logic [VW-1:0] V_LAST   = VW'(VTOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_B = VW'(VFP);
    localparam logic [VW-1:0] V_SYNC_E = VW'(VFP + VPULSE);
    localparam logic [VW-1:0] V_ACT    = VW'(VTOTAL - VDISP);
    localparam logic [VW-1:0] V_BIT4   = VW'(16);
    localparam logic [BW-1:0] BAR_LAST = BW'(BARW - 1);

    logic [HW-1:0] r_hc;
    logic [VW-1:0] r_vc;
    logic [1:0]    r_mode;

    logic          r_pixReq;
    logic [XW-1:0] r_pixX;
    logic [YW-1:0] r_pixY;
    logic          r_checker;
    logic [BW-1:0] r_barCnt;
    logic [2:0]    r_barIdx;
    logic          r_hSync1;
    logic          r_vSync1;
    logic          r_frame1;

    logic          r_hs;
    logic          r_vs;
    logic          r_de;
    logic [23:0]   r_rgb;
    logic          r_frameStart;

    logic          w_hActive;
    logic          w_vActive;
    logic          w_active;
    logic          w_hSync;
    logic          w_vSync;
    logic          w_origin;
    logic          w_checker;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic [2:0]    w_barColour;
    logic [23:0]   w_pattern;

    assign w_hActive   = (r_hc >= H_ACT);
    assign w_vActive   = (r_vc >= V_ACT);
    assign w_active    = w_hActive && w_vActive;
    assign w_hSync     = (r_hc >= H_SYNC_B) && (r_hc < H_SYNC_E);
    assign w_vSync     = (r_vc >= V_SYNC_B) && (r_vc < V_SYNC_E);
    assign w_origin    = (r_hc == '0) && (r_vc == '0);
    assign w_x         = XW'(r_hc - H_ACT);
    assign w_y         = YW'(r_vc - V_ACT);
    assign w_checker   = ((((r_hc - H_ACT) & H_BIT4) != '0) ^ (((r_vc - V_ACT) & V_BIT4) != '0));
    assign w_barColour = ~r_barIdx;

    // Pattern mode only changes at the frame origin so a frame is never split between two patterns.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_hc   <= '0;
            r_vc   <= '0;
            r_mode <= 2'd0;
        end else begin
            if (w_origin)
                r_mode <= pattern_sel;
            if (r_hc == H_LAST) begin
                r_hc <= '0;
                r_vc <= (r_vc == V_LAST) ? '0 : r_vc + 1'b1;
            end else begin
                r_hc <= r_hc + 1'b1;
            end
        end
    end

    // Bar index restarts on the first active pixel of each line and steps every BARW pixels.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_pixReq  <= 1'b0;
            r_pixX    <= '0;
            r_pixY    <= '0;
            r_checker <= 1'b0;
            r_barCnt  <= '0;
            r_barIdx  <= 3'd0;
            r_hSync1  <= 1'b0;
            r_vSync1  <= 1'b0;
            r_frame1  <= 1'b0;
        end else begin
            r_pixReq  <= w_active;
            r_pixX    <= w_active ? w_x : '0;
            r_pixY    <= w_active ? w_y : '0;
            r_checker <= w_checker;
            r_hSync1  <= w_hSync;
            r_vSync1  <= w_vSync;
            r_frame1  <= w_origin;
            if (r_hc == H_ACT) begin
                r_barCnt <= '0;
                r_barIdx <= 3'd0;
            end else if (w_hActive) begin
                if (r_barCnt == BAR_LAST) begin
                    r_barCnt <= '0;
                    r_barIdx <= r_barIdx + 3'd1;
                end else begin
                    r_barCnt <= r_barCnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_pattern = 24'h000000;
        case (r_mode)
            2'd0:    w_pattern = pix_in;
            2'd1:    w_pattern = r_checker ? 24'h000000 : 24'hFFFFFF;
            2'd2:    w_pattern = {{8{w_barColour[2]}}, {8{w_barColour[1]}}, {8{w_barColour[0]}}};
            default: w_pattern = SOLID_RGB;
        endcase
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_hs         <= ~HS_POL;
            r_vs         <= ~VS_POL;
            r_de         <= 1'b0;
            r_rgb        <= 24'h000000;
            r_frameStart <= 1'b0;
        end else begin
            r_hs         <= r_hSync1 ? HS_POL : ~HS_POL;
            r_vs         <= r_vSync1 ? VS_POL : ~VS_POL;
            r_de         <= r_pixReq;
            r_rgb        <= r_pixReq ? w_pattern : 24'h000000;
            r_frameStart <= r_frame1;
        end
    end

    assign pix_req     = r_pixReq;
    assign pix_x       = r_pixX;
    assign pix_y       = r_pixY;
    assign video_hs    = r_hs;
    assign video_vs    = r_vs;
    assign video_de    = r_de;
    assign video_rgb   = r_rgb;
    assign frame_start = r_frameStart;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced-size raster for full-frame timing and pattern checks,
// plus an 800-wide instance for the colour-bar layout.
module tb_vga_timing_gen;

    localparam int HT  = 47;
    localparam int VT  = 28;
    localparam int HO  = 15;
    localparam int VO  = 8;
    localparam int FR  = HT * VT;
    localparam int BHT = 928;
    localparam int BHO = 128;
    localparam int BVO = 3;

    logic        clk;
    logic        rst;
    logic        barRst;
    logic [1:0]  patternSel;
    logic [1:0]  barSel;
    logic [23:0] pixIn;
    logic [23:0] barPixIn;

    logic        pixReq, hs, vs, de, frameStart;
    logic [4:0]  pixX;
    logic [4:0]  pixY;
    logic [23:0] rgb;

    logic        barReq, barHs, barVs, barDe, barFs;
    logic [9:0]  barPixX;
    logic [3:0]  barPixY;
    logic [23:0] barRgb;

    int edgeCnt;
    int totalChecks = 0;
    int badChecks   = 0;

    vga_timing_gen #(
        .HDISP(32), .VDISP(20), .HFP(4), .HPULSE(6), .HBP(5),
        .VFP(2), .VPULSE(3), .VBP(3)
    ) dut (
        .pixel_clk(clk), .pixel_rst(rst), .pattern_sel(patternSel),
        .pix_req(pixReq), .pix_x(pixX), .pix_y(pixY), .pix_in(pixIn),
        .video_hs(hs), .video_vs(vs), .video_de(de), .video_rgb(rgb),
        .frame_start(frameStart)
    );

    vga_timing_gen #(
        .VDISP(16), .VFP(1), .VPULSE(1), .VBP(1)
    ) barDut (
        .pixel_clk(clk), .pixel_rst(barRst), .pattern_sel(barSel),
        .pix_req(barReq), .pix_x(barPixX), .pix_y(barPixY), .pix_in(barPixIn),
        .video_hs(barHs), .video_vs(barVs), .video_de(barDe), .video_rgb(barRgb),
        .frame_start(barFs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since the last reset release; outputs seen after edge n belong to counter step n-2.
    always @(posedge clk or posedge rst) begin
        if (rst) edgeCnt <= 0;
        else     edgeCnt <= edgeCnt + 1;
    end

    // External pixel source answers the request one cycle later with its own coordinates.
    always @(negedge clk) pixIn = {8'(pixY), 8'(pixX), 8'h5A};

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, bad=%0d", badChecks);
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic stepTo(input int n);
        while (edgeCnt < n) @(negedge clk);
    endtask

    function automatic int pixN(input int f, input int x, input int y);
        return f * FR + (y + VO) * HT + x + HO + 2;
    endfunction

    task automatic checkPixel(input string tag, input int f, input int x, input int y, input logic [23:0] exp);
        stepTo(pixN(f, x, y));
        checkOutput(tag, rgb, exp);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "Req"}, pixReq, 0);
        checkOutput({tag, "X"}, pixX, 0);
        checkOutput({tag, "Y"}, pixY, 0);
        checkOutput({tag, "Hs"}, hs, 1);
        checkOutput({tag, "Vs"}, vs, 1);
        checkOutput({tag, "De"}, de, 0);
        checkOutput({tag, "Rgb"}, rgb, 0);
        checkOutput({tag, "Fs"}, frameStart, 0);
    endtask

    // Walks whole frames cycle by cycle; mode 3 expects the solid colour, mode 0 the pixel-source data.
    task automatic scanFrames(input string label, input int firstFrame, input int numFrames, input int mode);
        int t, hc, vc, hc1, vc1, x, y;
        logic expHs, expVs, expDe, expFs, expReq;
        logic [23:0] expRgb;
        int badHs = 0, badVs = 0, badDe = 0, badRgb = 0, badFs = 0, badReq = 0;
        int hsLow = 0, vsLow = 0, deHigh = 0, fsCnt = 0, lastFs = -1, period = 0;
        for (int n = firstFrame * FR + 2; n < (firstFrame + numFrames) * FR + 2; n++) begin
            stepTo(n);
            t  = n - 2;
            hc = t % HT;
            vc = (t / HT) % VT;
            x  = hc - HO;
            y  = vc - VO;
            expHs  = !(hc >= 4 && hc < 10);
            expVs  = !(vc >= 2 && vc < 5);
            expDe  = (hc >= HO) && (vc >= VO);
            expFs  = (hc == 0) && (vc == 0);
            expRgb = !expDe ? 24'h0 : (mode == 3) ? 24'hFF0000 : {8'(y), 8'(x), 8'h5A};
            hc1 = (t + 1) % HT;
            vc1 = ((t + 1) / HT) % VT;
            expReq = (hc1 >= HO) && (vc1 >= VO);
            if (hs !== expHs) badHs++;
            if (vs !== expVs) badVs++;
            if (de !== expDe) badDe++;
            if (rgb !== expRgb) badRgb++;
            if (frameStart !== expFs) badFs++;
            if (pixReq !== expReq ||
                pixX !== (expReq ? 5'(hc1 - HO) : 5'd0) ||
                pixY !== (expReq ? 5'(vc1 - VO) : 5'd0)) badReq++;
            if (hs == 1'b0) hsLow++;
            if (vs == 1'b0) vsLow++;
            if (de == 1'b1) deHigh++;
            if (frameStart == 1'b1) begin
                fsCnt++;
                if (lastFs >= 0) period = n - lastFs;
                lastFs = n;
            end
        end
        checkOutput({label, "HsSeq"}, badHs, 0);
        checkOutput({label, "VsSeq"}, badVs, 0);
        checkOutput({label, "DeSeq"}, badDe, 0);
        checkOutput({label, "RgbSeq"}, badRgb, 0);
        checkOutput({label, "FsSeq"}, badFs, 0);
        checkOutput({label, "ReqSeq"}, badReq, 0);
        checkOutput({label, "HsLow"}, hsLow, numFrames * VT * 6);
        checkOutput({label, "VsLow"}, vsLow, numFrames * 3 * HT);
        checkOutput({label, "DeHigh"}, deHigh, numFrames * 32 * 20);
        checkOutput({label, "FsCount"}, fsCnt, numFrames);
        if (numFrames > 1) checkOutput({label, "FsPeriod"}, period, FR);
    endtask

    task automatic applyStimulus();
        fork
            begin : mainFlow
                stepTo(1); checkOutput("fsEdge1", frameStart, 0);
                stepTo(2); checkOutput("fsEdge2", frameStart, 1);
                stepTo(3); checkOutput("fsEdge3", frameStart, 0);
                stepTo(391); checkOutput("reqBeforeActive", pixReq, 0);
                stepTo(392); checkOutput("reqFirst", pixReq, 1);
                checkOutput("deLagsReq", de, 0);
                stepTo(393); checkOutput("deFirst", de, 1);
                checkPixel("ckr_0_0", 0, 0, 0, 24'hFFFFFF);
                checkPixel("ckr_15_0", 0, 15, 0, 24'hFFFFFF);
                checkPixel("ckr_16_0", 0, 16, 0, 24'h000000);
                stepTo(18 * HT);
                patternSel = 2'd3;
                checkPixel("ckrAfterSel_0_12", 0, 0, 12, 24'hFFFFFF);
                checkPixel("ckrAfterSel_0_16", 0, 0, 16, 24'h000000);
                checkPixel("ckrAfterSel_16_16", 0, 16, 16, 24'hFFFFFF);
                checkPixel("ckrLastPixel", 0, 31, 19, 24'hFFFFFF);
                fork
                    begin
                        stepTo(2 * FR + 500);
                        patternSel = 2'd0;
                    end
                join_none
                scanFrames("solid", 1, 2, 3);
                scanFrames("ext", 3, 1, 0);
            end
            begin : barFlow
                int barX[9] = '{0, 99, 100, 199, 200, 399, 400, 700, 799};
                logic [23:0] barExp[9] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00,
                                           24'hFF00FF, 24'hFF0000, 24'h00FFFF, 24'h000000, 24'h000000};
                int hc, hsLow = 0, deHigh = 0, oddSync = 0;
                for (int n = BVO * BHT + 2; n < (BVO + 1) * BHT + 2; n++) begin
                    stepTo(n);
                    hc = n - 2 - BVO * BHT;
                    if (barHs == 1'b0) hsLow++;
                    if (barDe == 1'b1) deHigh++;
                    if (barVs == 1'b0 || barFs == 1'b1) oddSync++;
                    for (int j = 0; j < 9; j++)
                        if (hc == BHO + barX[j]) checkOutput($sformatf("bar_%0d", barX[j]), barRgb, barExp[j]);
                    if (hc + 1 == BHO + 100) begin
                        checkOutput("barReq", barReq, 1);
                        checkOutput("barPixX", barPixX, 100);
                        checkOutput("barPixY", barPixY, 0);
                    end
                end
                checkOutput("barHsLow", hsLow, 48);
                checkOutput("barDeHigh", deHigh, 800);
                checkOutput("barVsFs", oddSync, 0);
            end
        join
    endtask

    initial begin
        rst        = 1'b1;
        barRst     = 1'b1;
        patternSel = 2'd1;
        barSel     = 2'd2;
        barPixIn   = 24'h0;
        repeat (3) @(negedge clk);
        checkResetState("init");
        rst    = 1'b0;
        barRst = 1'b0;
        applyStimulus();

        stepTo(pixN(4, 15, 7));
        checkOutput("preResetDe", de, 1);
        rst = 1'b1;
        #1;
        checkResetState("rstNow");
        repeat (3) @(negedge clk);
        checkResetState("rstHeld");
        rst = 1'b0;
        stepTo(1); checkOutput("rstFsEdge1", frameStart, 0);
        scanFrames("postRst", 0, 1, 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
